// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types plus the scheduler's response codes, FSM states and buffered payload records.
package axi_lite_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;
   typedef logic [1:0]  resp_t;
   typedef logic [2:0]  prot_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WAIT,
      BRESP,
      RRESP
   } sched_state_e;

   typedef struct packed {
      addr_t addr;
      prot_t prot;
   } addr_req_t;

   typedef struct packed {
      data_t data;
      strb_t strb;
   } wdat_req_t;

endpackage

// File: rtl/axi_lite_rw_scheduler_if.sv
// AXI4-Lite slave channels plus the cmd/rsp link to the APB sequencing core.
// The slave modport is the scheduler's view; master is the surrounding system (AXI master + APB core).
interface axi_lite_rw_scheduler_if;
   import axi_lite_pkg::*;

   addr_t s_axi_awaddr;
   prot_t s_axi_awprot;
   logic  s_axi_awvalid;
   logic  s_axi_awready;
   data_t s_axi_wdata;
   strb_t s_axi_wstrb;
   logic  s_axi_wvalid;
   logic  s_axi_wready;
   resp_t s_axi_bresp;
   logic  s_axi_bvalid;
   logic  s_axi_bready;
   addr_t s_axi_araddr;
   prot_t s_axi_arprot;
   logic  s_axi_arvalid;
   logic  s_axi_arready;
   data_t s_axi_rdata;
   resp_t s_axi_rresp;
   logic  s_axi_rvalid;
   logic  s_axi_rready;

   logic  cmd_valid;
   logic  cmd_ready;
   logic  cmd_write;
   addr_t cmd_addr;
   data_t cmd_wdata;
   strb_t cmd_wstrb;
   prot_t cmd_prot;
   logic  rsp_valid;
   data_t rsp_rdata;
   logic  rsp_err;

   modport slave (
      input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_rready,
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_rready,
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/axi_lite_req_buf.sv
// One-entry request holding register: push handshake latches payload, pop frees it; 1-cycle fill latency.
// Backpressure: ready is low while full (or in reset) until the consumer pops the entry.
module axi_lite_req_buf #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic push_vld,
   output logic push_rdy,
   input  T     push_dat,
   input  logic pop,
   output logic full,
   output T     dat
);

   assign push_rdy = !full && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         dat  <= '0;
      end else if (pop) begin
         full <= 1'b0;
      end else if (push_vld && push_rdy) begin
         full <= 1'b1;
         dat  <= push_dat;
      end
   end

endmodule

// File: rtl/axi_lite_rw_scheduler.sv
// Round-robin read/write scheduler feeding the APB core one command at a time; cmd_valid 2 cycles after AXI accept.
// Backpressure: each AXI channel buffers one request; B/R are held until bready/rready, with SLVERR on rsp timeout.
module axi_lite_rw_scheduler
   import axi_lite_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES    = 256,
   parameter bit          FIRST_GRANT_WRITE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   axi_lite_rw_scheduler_if.slave  bus
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   sched_state_e state, state_nxt;
   addr_req_t    aw_in, aw_dat, ar_in, ar_dat;
   wdat_req_t    w_in, w_dat;
   logic         aw_full, w_full, ar_full, aw_rdy, w_rdy, ar_rdy;
   logic         pop_wr, pop_rd, write_elig, read_elig, done;
   resp_t        rsp_resp;
   logic [TW-1:0] timer, timer_nxt;
   logic         last_write, last_write_nxt;
   logic         cmd_valid, cmd_valid_nxt, cmd_write, cmd_write_nxt;
   addr_t        cmd_addr, cmd_addr_nxt;
   data_t        cmd_wdata, cmd_wdata_nxt, rdata, rdata_nxt;
   strb_t        cmd_wstrb, cmd_wstrb_nxt;
   prot_t        cmd_prot, cmd_prot_nxt;
   logic         bvalid, bvalid_nxt, rvalid, rvalid_nxt;
   resp_t        bresp, bresp_nxt, rresp, rresp_nxt;

   assign aw_in = '{addr: bus.s_axi_awaddr, prot: bus.s_axi_awprot};
   assign w_in  = '{data: bus.s_axi_wdata, strb: bus.s_axi_wstrb};
   assign ar_in = '{addr: bus.s_axi_araddr, prot: bus.s_axi_arprot};

   axi_lite_req_buf #(.T(addr_req_t)) u_aw_buf (
      .clk(clk), .rst(rst), .push_vld(bus.s_axi_awvalid), .push_rdy(aw_rdy),
      .push_dat(aw_in), .pop(pop_wr), .full(aw_full), .dat(aw_dat)
   );
   axi_lite_req_buf #(.T(wdat_req_t)) u_w_buf (
      .clk(clk), .rst(rst), .push_vld(bus.s_axi_wvalid), .push_rdy(w_rdy),
      .push_dat(w_in), .pop(pop_wr), .full(w_full), .dat(w_dat)
   );
   axi_lite_req_buf #(.T(addr_req_t)) u_ar_buf (
      .clk(clk), .rst(rst), .push_vld(bus.s_axi_arvalid), .push_rdy(ar_rdy),
      .push_dat(ar_in), .pop(pop_rd), .full(ar_full), .dat(ar_dat)
   );

   assign write_elig = aw_full && w_full;
   assign read_elig  = ar_full;
   // A response arriving in the same cycle as the timeout takes priority over it.
   assign done       = bus.rsp_valid || ((TIMEOUT_CYCLES != 0) && (timer == TO_LAST));
   assign rsp_resp   = (bus.rsp_valid && !bus.rsp_err) ? RESP_OKAY : RESP_SLVERR;

   always_comb begin
      state_nxt      = state;
      cmd_valid_nxt  = cmd_valid;
      cmd_write_nxt  = cmd_write;
      cmd_addr_nxt   = cmd_addr;
      cmd_wdata_nxt  = cmd_wdata;
      cmd_wstrb_nxt  = cmd_wstrb;
      cmd_prot_nxt   = cmd_prot;
      timer_nxt      = timer;
      bvalid_nxt     = bvalid;
      bresp_nxt      = bresp;
      rvalid_nxt     = rvalid;
      rresp_nxt      = rresp;
      rdata_nxt      = rdata;
      last_write_nxt = last_write;
      pop_wr         = 1'b0;
      pop_rd         = 1'b0;
      case (state)
         IDLE: begin
            if (write_elig && (!read_elig || !last_write)) begin
               cmd_valid_nxt = 1'b1;
               cmd_write_nxt = 1'b1;
               cmd_addr_nxt  = aw_dat.addr;
               cmd_wdata_nxt = w_dat.data;
               cmd_wstrb_nxt = w_dat.strb;
               cmd_prot_nxt  = aw_dat.prot;
               state_nxt     = CMD;
            end else if (read_elig) begin
               cmd_valid_nxt = 1'b1;
               cmd_write_nxt = 1'b0;
               cmd_addr_nxt  = ar_dat.addr;
               cmd_wdata_nxt = '0;
               cmd_wstrb_nxt = '0;
               cmd_prot_nxt  = ar_dat.prot;
               state_nxt     = CMD;
            end
         end
         CMD: begin
            if (bus.cmd_ready) begin
               cmd_valid_nxt = 1'b0;
               timer_nxt     = '0;
               state_nxt     = WAIT;
            end
         end
         WAIT: begin
            timer_nxt = timer + TW'(1);
            if (done) begin
               if (cmd_write) begin
                  bvalid_nxt = 1'b1;
                  bresp_nxt  = rsp_resp;
                  pop_wr     = 1'b1;
                  state_nxt  = BRESP;
               end else begin
                  rvalid_nxt = 1'b1;
                  rresp_nxt  = rsp_resp;
                  rdata_nxt  = bus.rsp_valid ? bus.rsp_rdata : '0;
                  pop_rd     = 1'b1;
                  state_nxt  = RRESP;
               end
            end
         end
         BRESP: begin
            if (bus.s_axi_bready) begin
               bvalid_nxt     = 1'b0;
               last_write_nxt = 1'b1;
               state_nxt      = IDLE;
            end
         end
         RRESP: begin
            if (bus.s_axi_rready) begin
               rvalid_nxt     = 1'b0;
               last_write_nxt = 1'b0;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd_valid  <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_wstrb  <= '0;
         cmd_prot   <= '0;
         timer      <= '0;
         bvalid     <= 1'b0;
         bresp      <= RESP_OKAY;
         rvalid     <= 1'b0;
         rresp      <= RESP_OKAY;
         rdata      <= '0;
         last_write <= !FIRST_GRANT_WRITE;
      end else begin
         state      <= state_nxt;
         cmd_valid  <= cmd_valid_nxt;
         cmd_write  <= cmd_write_nxt;
         cmd_addr   <= cmd_addr_nxt;
         cmd_wdata  <= cmd_wdata_nxt;
         cmd_wstrb  <= cmd_wstrb_nxt;
         cmd_prot   <= cmd_prot_nxt;
         timer      <= timer_nxt;
         bvalid     <= bvalid_nxt;
         bresp      <= bresp_nxt;
         rvalid     <= rvalid_nxt;
         rresp      <= rresp_nxt;
         rdata      <= rdata_nxt;
         last_write <= last_write_nxt;
      end
   end

   assign bus.s_axi_awready = aw_rdy;
   assign bus.s_axi_wready  = w_rdy;
   assign bus.s_axi_arready = ar_rdy;
   assign bus.s_axi_bvalid  = bvalid;
   assign bus.s_axi_bresp   = bresp;
   assign bus.s_axi_rvalid  = rvalid;
   assign bus.s_axi_rresp   = rresp;
   assign bus.s_axi_rdata   = rdata;
   assign bus.cmd_valid     = cmd_valid;
   assign bus.cmd_write     = cmd_write;
   assign bus.cmd_addr      = cmd_addr;
   assign bus.cmd_wdata     = cmd_wdata;
   assign bus.cmd_wstrb     = cmd_wstrb;
   assign bus.cmd_prot      = cmd_prot;

endmodule
